// File: rtl/code_send_sequencer.sv
// code_send_sequencer
//  Buffers keypad digits and, on submit, streams them one at a time into the
//  single-digit sender stage: present num with enabled high until done, then
//  hold enabled low for a gap so the sender clears before the next digit.
//  Optional feature macro: SEND_TERM_EN appends a TERM_CODE digit to each code.
module code_send_sequencer #(
  parameter int          DEPTH      = 4,
  parameter int          PTR_W      = 2,
  parameter int          GAP_CYCLES = 120000,
  parameter logic [3:0]  TERM_CODE  = 4'd7
) (
  input  logic             hwclk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [3:0]       key_num,
  input  logic             submit,
  input  logic             clear,
  output logic [3:0]       snd_num,
  output logic             snd_enabled,
  input  logic             snd_done,
  output logic             busy,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             overflow,
  output logic             sent
);

  // A zero gap still needs one low cycle so the sender can drop done.
  localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int GAP_W   = $clog2(GAP_EFF + 1);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_EFF - 1);
  localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W + 1)'(0);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_LAST = (PTR_W + 1)'(DEPTH - 1);

`ifdef SEND_TERM_EN
  localparam logic TERM_EN = 1'b1;
`else
  localparam logic TERM_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           state_r;
  logic [3:0]       buf_r [DEPTH];
  logic [PTR_W:0]   count_r;
  logic [PTR_W:0]   rd_ptr_r;   // one extra bit so it can step past a full buffer
  logic [GAP_W-1:0] gap_cnt_r;
  logic             term_r;     // terminator pass of the current code in progress
  logic [3:0]       snd_num_r;
  logic             snd_enabled_r;
  logic             busy_r;
  logic             full_r;
  logic             overflow_r;
  logic             sent_r;

  logic             key_ok_s;
  logic [3:0]       first_num_s;

  // Key acceptance and the first digit to present when a send starts.
  always_comb begin
    key_ok_s    = 1'b0;
    first_num_s = 4'd0;
    if (key_valid && !full_r) begin
      key_ok_s = 1'b1;
    end else begin
      key_ok_s = 1'b0;
    end
    // Empty buffer with a same-cycle key: that key is the first digit.
    if (count_r == CNT_ZERO) begin
      first_num_s = key_num;
    end else begin
      first_num_s = buf_r[0];
    end
  end

  // Sequencer FSM with buffer storage and registered outputs.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) buf_r[i] <= 4'd0;
      count_r       <= CNT_ZERO;
      rd_ptr_r      <= CNT_ZERO;
      gap_cnt_r     <= GAP_ZERO;
      term_r        <= 1'b0;
      snd_num_r     <= 4'd0;
      snd_enabled_r <= 1'b0;
      busy_r        <= 1'b0;
      full_r        <= 1'b0;
      overflow_r    <= 1'b0;
      sent_r        <= 1'b0;
    end else if (clear) begin
      state_r       <= ST_IDLE;
      count_r       <= CNT_ZERO;
      rd_ptr_r      <= CNT_ZERO;
      gap_cnt_r     <= GAP_ZERO;
      term_r        <= 1'b0;
      snd_num_r     <= 4'd0;
      snd_enabled_r <= 1'b0;
      busy_r        <= 1'b0;
      full_r        <= 1'b0;
      overflow_r    <= 1'b0;
      sent_r        <= 1'b0;
    end else begin
      sent_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (key_ok_s) begin
            buf_r[count_r[PTR_W-1:0]] <= key_num;
            count_r                   <= count_r + CNT_ONE;
            full_r                    <= (count_r == CNT_LAST);
          end else if (key_valid) begin
            overflow_r <= 1'b1;
          end
          // Submit is evaluated after the same-cycle key so it is included.
          if (submit && ((count_r != CNT_ZERO) || key_ok_s)) begin
            state_r       <= ST_SEND;
            snd_enabled_r <= 1'b1;
            snd_num_r     <= first_num_s;
            rd_ptr_r      <= CNT_ZERO;
            term_r        <= 1'b0;
            busy_r        <= 1'b1;
          end
        end
        ST_SEND: begin
          if (snd_done) begin
            state_r       <= ST_GAP;
            snd_enabled_r <= 1'b0;
            rd_ptr_r      <= rd_ptr_r + CNT_ONE;
            gap_cnt_r     <= GAP_ZERO;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            gap_cnt_r <= GAP_ZERO;
            if (rd_ptr_r < count_r) begin
              state_r       <= ST_SEND;
              snd_enabled_r <= 1'b1;
              snd_num_r     <= buf_r[rd_ptr_r[PTR_W-1:0]];
            end else if (TERM_EN && !term_r) begin
              state_r       <= ST_SEND;
              snd_enabled_r <= 1'b1;
              snd_num_r     <= TERM_CODE;
              term_r        <= 1'b1;
            end else begin
              state_r    <= ST_IDLE;
              count_r    <= CNT_ZERO;
              rd_ptr_r   <= CNT_ZERO;
              term_r     <= 1'b0;
              overflow_r <= 1'b0;
              full_r     <= 1'b0;
              busy_r     <= 1'b0;
              sent_r     <= 1'b1;
            end
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_ONE;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean idle.
          state_r       <= ST_IDLE;
          count_r       <= CNT_ZERO;
          rd_ptr_r      <= CNT_ZERO;
          gap_cnt_r     <= GAP_ZERO;
          term_r        <= 1'b0;
          snd_num_r     <= 4'd0;
          snd_enabled_r <= 1'b0;
          busy_r        <= 1'b0;
          full_r        <= 1'b0;
          overflow_r    <= 1'b0;
        end
      endcase
    end
  end

  assign snd_num     = snd_num_r;
  assign snd_enabled = snd_enabled_r;
  assign busy        = busy_r;
  assign count       = count_r;
  assign full        = full_r;
  assign overflow    = overflow_r;
  assign sent        = sent_r;

endmodule

// File: tb/tb_code_send_sequencer.sv
// Bench for code_send_sequencer (DEPTH=4, GAP_CYCLES=4) with a stub sender
// that raises done 10 cycles after enabled rises and holds it until enabled falls.
// Expected digits are queued when a code is submitted and popped on each
// rising snd_enabled.
module tb_code_send_sequencer;

  localparam int GAP = 4;

  logic       hwclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_num = 4'd0;
  logic       submit = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] snd_num;
  logic       snd_enabled;
  logic       snd_done;
  logic       busy;
  logic [2:0] count;
  logic       full;
  logic       overflow;
  logic       sent;

  int tests = 0;
  int fails = 0;

  logic [3:0] exp_q [$];
  int  rise_cnt = 0;
  int  sent_cnt = 0;
  int  hi_len = 0;
  int  gap_len = 0;
  bit  gap_active = 1'b0;
  logic prev_en = 1'b0;
  logic prev_sent = 1'b0;
  logic [3:0] cur_num = 4'd0;

  int  stub_cnt = 0;
  logic stub_done = 1'b0;
  assign snd_done = stub_done;

  code_send_sequencer #(
    .DEPTH(4), .PTR_W(2), .GAP_CYCLES(GAP), .TERM_CODE(4'd7)
  ) dut (
    .hwclk(hwclk), .rst_n(rst_n), .key_valid(key_valid), .key_num(key_num),
    .submit(submit), .clear(clear), .snd_num(snd_num), .snd_enabled(snd_enabled),
    .snd_done(snd_done), .busy(busy), .count(count), .full(full),
    .overflow(overflow), .sent(sent)
  );

  always #5 hwclk = ~hwclk;

  // Stub sender: done 10 cycles after enabled rises, cleared once enabled drops.
  always @(posedge hwclk or negedge rst_n) begin
    if (!rst_n || !snd_enabled) begin
      stub_cnt  <= 0;
      stub_done <= 1'b0;
    end else begin
      stub_cnt  <= stub_cnt + 1;
      stub_done <= (stub_cnt + 1 >= 10);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor: digit order, enable hold time, gap length, sent pulse width.
  always @(negedge hwclk) begin
    if (snd_enabled && !prev_en) begin
      rise_cnt++;
      if (gap_active) check("gap_len", gap_len, GAP);
      gap_active = 1'b0;
      if (exp_q.size() == 0) begin
        check("unexpected_digit", int'(snd_num), -1);
      end else begin
        check("digit", int'(snd_num), int'(exp_q.pop_front()));
      end
      cur_num = snd_num;
      hi_len = 1;
    end else if (snd_enabled) begin
      hi_len++;
      check("num_stable", int'(snd_num), int'(cur_num));
    end
    if (!snd_enabled && prev_en && busy) begin
      check("enable_hold", hi_len, 11);
      gap_active = 1'b1;
      gap_len = 1;
    end else if (!snd_enabled && gap_active) begin
      gap_len++;
    end
    if (!busy) gap_active = 1'b0;
    if (sent) begin
      sent_cnt++;
      check("sent_width", int'(prev_sent), 0);
    end
    prev_en = snd_enabled;
    prev_sent = sent;
  end

  task automatic tick();
    @(negedge hwclk);
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_num = d;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic do_submit();
    submit = 1'b1;
    tick();
    submit = 1'b0;
  endtask

  task automatic push_term();
`ifdef SEND_TERM_EN
    exp_q.push_back(4'd7);
`endif
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 2000);
    check({tag, "_timeout"}, int'(n < 2000), 1);
    tick();
  endtask

  initial begin
    int base;
    int n;
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    repeat (3) tick();
    // Reset state
    check("rst_num", int'(snd_num), 0);
    check("rst_en", int'(snd_enabled), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(count), 0);
    check("rst_full", int'(full), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_sent", int'(sent), 0);
    rst_n = 1'b1;
    tick();

    // T1: 3,1,4
    key(4'd3); key(4'd1); key(4'd4);
    check("t1_count", int'(count), 3);
    exp_q.push_back(4'd3); exp_q.push_back(4'd1); exp_q.push_back(4'd4); push_term();
    base = sent_cnt;
    do_submit();
    check("t1_latency_en", int'(snd_enabled), 1);
    check("t1_busy", int'(busy), 1);
    wait_idle("t1");
    check("t1_sent", sent_cnt - base, 1);
    check("t1_count_end", int'(count), 0);
    check("t1_queue", exp_q.size(), 0);

    // T2: overflow, digit 5 dropped
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    check("t2_count", int'(count), 4);
    check("t2_full", int'(full), 1);
    check("t2_ovf", int'(overflow), 1);
    exp_q.push_back(4'd1); exp_q.push_back(4'd2);
    exp_q.push_back(4'd3); exp_q.push_back(4'd4); push_term();
    base = sent_cnt;
    do_submit();
    wait_idle("t2");
    check("t2_sent", sent_cnt - base, 1);
    check("t2_full_end", int'(full), 0);
    check("t2_ovf_end", int'(overflow), 0);
    check("t2_queue", exp_q.size(), 0);

    // T3: empty submit ignored; key+submit same cycle
    do_submit();
    check("t3_empty_en", int'(snd_enabled), 0);
    check("t3_empty_busy", int'(busy), 0);
    exp_q.push_back(4'd6); push_term();
    base = sent_cnt;
    key_valid = 1'b1; key_num = 4'd6; submit = 1'b1;
    tick();
    key_valid = 1'b0; submit = 1'b0;
    check("t3_same_en", int'(snd_enabled), 1);
    wait_idle("t3");
    check("t3_sent", sent_cnt - base, 1);
    check("t3_queue", exp_q.size(), 0);

    // T4: clear during 2nd digit's SEND
    key(4'd1); key(4'd2); key(4'd3);
    exp_q.push_back(4'd1); exp_q.push_back(4'd2);
    base = rise_cnt;
    n = sent_cnt;
    do_submit();
    begin
      int k = 0;
      while (rise_cnt < base + 2 && k < 500) begin tick(); k++; end
      check("t4_timeout", int'(k < 500), 1);
    end
    tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t4_en", int'(snd_enabled), 0);
    check("t4_busy", int'(busy), 0);
    check("t4_count", int'(count), 0);
    check("t4_num", int'(snd_num), 0);
    repeat (40) tick();
    check("t4_no_sent", sent_cnt - n, 0);
    check("t4_rises", rise_cnt - base, 2);
    check("t4_queue", exp_q.size(), 0);

    // T5: keys while busy are ignored
    key(4'd9); key(4'd8);
    exp_q.push_back(4'd9); exp_q.push_back(4'd8); push_term();
    base = sent_cnt;
    do_submit();
    tick();
    key(4'd5);
    check("t5_busy_count", int'(count), 2);
    check("t5_busy_ovf", int'(overflow), 0);
    wait_idle("t5");
    check("t5_sent", sent_cnt - base, 1);
    check("t5_count_end", int'(count), 0);
    check("t5_queue", exp_q.size(), 0);

    // T6: 2,5 (plus terminator when enabled)
    key(4'd2); key(4'd5);
    exp_q.push_back(4'd2); exp_q.push_back(4'd5); push_term();
    base = sent_cnt;
    do_submit();
    wait_idle("t6");
    check("t6_sent", sent_cnt - base, 1);
    check("t6_queue", exp_q.size(), 0);

    // Async reset mid-send
    key(4'd4);
    exp_q.push_back(4'd4);
    do_submit();
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_en", int'(snd_enabled), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_count", int'(count), 0);
    check("rst_mid_num", int'(snd_num), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("rst_mid_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
